sudoku_group_scan: RTL and testbench
====================================

# sudoku_group_scan

Sequential, parametrised constraint checker for an N²×N²×N² one-hot candidate cube. It captures the cube on `start` and scans it one constraint group per cycle: cell, x-line, y-line and box groups, with optional per-class enables. It reports solved, conflict and incomplete status, a conflict count, and the first conflict location. It sits beside the combinational partials generator in the sudoku check datapath and replaces the wide parallel compare with a small serial engine.

## Interface
- `BOX`, default 3: box edge. Derived values: `S = BOX*BOX` is the grid side, `G = S*S` is the number of groups per class, `CW = clog2(4*G+1)`, `GW = clog2(G)`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a scan. Accepted only in IDLE or DONE.
- `cube` in S*S*S: bit(x,y,z) = `cube[x*S*S + y*S + z]`. Sampled only on the accepted start edge.
- `class_en` in 4: enables for class 0 cell, class 1 x-line, class 2 y-line, class 3 box. Sampled with start.
- `stop_on_conflict` in 1: sampled with start. Ends the scan at the first conflicting group.
- `busy` out 1: high while in SCAN.
- `done` out 1: one-cycle pulse when results are valid.
- `solved` out 1: every evaluated group had exactly one set bit.
- `conflict` out 1: some evaluated group had two or more set bits.
- `incomplete` out 1: some evaluated group had zero set bits.
- `conflict_cnt` out CW: number of conflicting groups.
- `first_cls` out 2: class of the first conflict.
- `first_grp` out GW: group index of the first conflict.

## Operation
- Group g, with g = a*S + b, is defined per class as follows:
  - Class 0: x=a, y=b; the set bit runs over z.
  - Class 1: y=a, z=b; runs over x.
  - Class 2: x=a, z=b; runs over y.
  - Class 3: box a, digit z=b. Runs over x in [(a/BOX)*BOX, +BOX) and y in [(a%BOX)*BOX, +BOX).
- Each group's S bits are popcounted and classified as 0 (empty), 1 (ok) or ≥2 (conflict).
- FSM states:
  - IDLE: on start, capture inputs and clear all result registers.
    - If `class_en`≠0, go to SCAN at the lowest enabled class, grp=0.
    - Otherwise go to DONE.
  - SCAN: evaluate one group per cycle.
    - After grp=G-1, jump to the next higher enabled class. If there is none, go to DONE.
    - Disabled classes consume zero cycles.
    - If `stop_on_conflict` is set and the current group conflicts, go to DONE after registering that group.
  - DONE: `done`=1 for this cycle. A start here is accepted exactly as in IDLE. Otherwise go to IDLE.
- Result registers hold their values through IDLE until the next accepted start.
- `solved` = NOT conflict AND NOT incomplete, computed over evaluated groups. It is 1 when `class_en`=0.
- `conflict_cnt` increments once per conflicting group and cannot overflow (max 4*G).
- `first_cls`/`first_grp` are loaded on the first conflict only and stay 0 if no conflict occurs.
- `start` during SCAN is ignored. The captured cube is immune to `cube` changes during a scan.

## Timing
- Reset: every output is 0 and the FSM is in IDLE, asynchronously. This applies mid-scan as well; the scan is abandoned with no `done`.
- Start is accepted at edge 0. Groups are evaluated in cycles 1..K, where K = G × (number of enabled classes), and `done` is high in cycle K+1.
- With `BOX`=3 and all classes enabled: `busy` is high in cycles 1..324 and `done` is high in cycle 325.
- `class_en`=0: `done` is high in cycle 1.
- Result outputs read 0 from cycle 1 and are final in the `done` cycle.

## Test plan
- Valid solved 9×9 grid, `class_en`=4'hF: `done` in cycle 325; `solved`=1, `conflict`=0, `incomplete`=0, `conflict_cnt`=0.
- Same grid with cell (4,0) changed to the digit d of cell (0,0): `conflict_cnt`=3, `incomplete`=1, `solved`=0, `first_cls`=1, `first_grp`=d.
- Previous stimulus with `stop_on_conflict`=1: `done` in cycle 83+d, `conflict_cnt`=1, `first_cls`=1, `first_grp`=d.
- All-zero cube, `class_en`=4'b0001: `done` in cycle 82, `incomplete`=1, `conflict`=0. Repeat with `class_en`=0: `done` in cycle 1 with `solved`=1.
- Pull `rst_n` low in cycle 100 of a full scan: all outputs 0 immediately and no `done`. A following start completes normally at start+325. A start pulse during SCAN has no effect.
- `BOX`=2, valid 4×4 solution: `done` in cycle 65 with `solved`=1. Also drive a back-to-back start in the DONE cycle and check a second `done` 65 cycles later.

Source files
------------

// File: rtl/sudoku_group_scan_if.sv
// sudoku_group_scan_if: request/result bundle for the serial sudoku group checker
//   master: start, cube, class_en, stop_on_conflict  -> checker
//   slave : busy, done, solved, conflict, incomplete,
//           conflict_cnt, first_cls, first_grp       -> requester
interface sudoku_group_scan_if #(parameter int BOX = 3);
    localparam int S  = BOX * BOX;
    localparam int G  = S * S;
    localparam int CW = $clog2(4 * G + 1);
    localparam int GW = $clog2(G);
    logic             start;
    logic [S*S*S-1:0] cube;
    logic [3:0]       class_en;
    logic             stop_on_conflict;
    logic             busy;
    logic             done;
    logic             solved;
    logic             conflict;
    logic             incomplete;
    logic [CW-1:0]    conflict_cnt;
    logic [1:0]       first_cls;
    logic [GW-1:0]    first_grp;
    modport master (
        output start, cube, class_en, stop_on_conflict,
        input  busy, done, solved, conflict, incomplete, conflict_cnt, first_cls, first_grp
    );
    modport slave (
        input  start, cube, class_en, stop_on_conflict,
        output busy, done, solved, conflict, incomplete, conflict_cnt, first_cls, first_grp
    );
endinterface

// File: rtl/sudoku_group_scan.sv
// sudoku_group_scan: serial one-group-per-cycle constraint checker for a one-hot candidate cube
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sudoku_group_scan_if.slave (request in, status/results out, all registered)
module sudoku_group_scan #(
    parameter int BOX = 3
) (
    input logic               clk,
    input logic               rst_n,
    sudoku_group_scan_if.slave bus
);
    localparam int S  = BOX * BOX;
    localparam int G  = S * S;
    localparam int GW = $clog2(G);
    localparam int SW = $clog2(S);
    localparam int IW = $clog2(S * S * S);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [S*S*S-1:0] cube_q;
    logic [3:0]       en_q;
    logic             stop_q;
    logic [1:0]       cls;
    logic [SW-1:0]    a;
    logic [SW-1:0]    b;
    logic [GW-1:0]    grp;
    logic [2:0]       lowest;
    logic [2:0]       nxt;
    logic             last;
    logic             g_conf;
    logic             g_empty;
    int               idx;
    int               pc;

    // Lowest enabled class at or above 'from'; 4 means none left.
    function automatic logic [2:0] next_cls(input logic [3:0] en, input int from);
        logic [2:0] r;
        r = 3'd4;
        for (int c = 3; c >= 0; c--)
            if (c >= from && en[c]) r = 3'(c);
        return r;
    endfunction

    assign lowest = next_cls(bus.class_en, 0);
    assign nxt    = next_cls(en_q, int'(cls) + 1);
    assign last   = grp == GW'(G - 1);

    // Gather the S bits of group (a,b) for the current class and popcount them.
    always_comb begin
        pc  = 0;
        idx = 0;
        for (int i = 0; i < S; i++) begin
            idx = (cls == 2'd0) ? int'(a) * S * S + int'(b) * S + i
                : (cls == 2'd1) ? i * S * S + int'(a) * S + int'(b)
                : (cls == 2'd2) ? int'(a) * S * S + i * S + int'(b)
                : ((int'(a) / BOX) * BOX + i / BOX) * S * S
                  + ((int'(a) % BOX) * BOX + i % BOX) * S + int'(b);
            pc = pc + int'(cube_q[idx[IW-1:0]]);
        end
    end

    assign g_conf  = pc > 1;
    assign g_empty = pc == 0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cube_q           <= '0;
            en_q             <= '0;
            stop_q           <= 1'b0;
            cls              <= '0;
            a                <= '0;
            b                <= '0;
            grp              <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.solved       <= 1'b0;
            bus.conflict     <= 1'b0;
            bus.incomplete   <= 1'b0;
            bus.conflict_cnt <= '0;
            bus.first_cls    <= '0;
            bus.first_grp    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                SCAN: begin
                    bus.conflict   <= bus.conflict | g_conf;
                    bus.incomplete <= bus.incomplete | g_empty;
                    if (g_conf) bus.conflict_cnt <= bus.conflict_cnt + 1'b1;
                    if (g_conf && !bus.conflict) begin
                        bus.first_cls <= cls;
                        bus.first_grp <= grp;
                    end
                    if ((g_conf && stop_q) || (last && nxt[2])) begin
                        state      <= DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.solved <= !(bus.conflict | g_conf) && !(bus.incomplete | g_empty);
                    end else begin
                        cls <= last ? nxt[1:0] : cls;
                        grp <= last ? '0 : grp + 1'b1;
                        b   <= (b == SW'(S - 1)) ? '0 : b + 1'b1;
                        a   <= last ? '0 : (b == SW'(S - 1)) ? a + 1'b1 : a;
                    end
                end
                default: if (bus.start) begin
                    cube_q           <= bus.cube;
                    en_q             <= bus.class_en;
                    stop_q           <= bus.stop_on_conflict;
                    cls              <= lowest[1:0];
                    a                <= '0;
                    b                <= '0;
                    grp              <= '0;
                    bus.conflict     <= 1'b0;
                    bus.incomplete   <= 1'b0;
                    bus.conflict_cnt <= '0;
                    bus.first_cls    <= '0;
                    bus.first_grp    <= '0;
                    // With nothing enabled the scan is trivially solved and finishes at once.
                    bus.solved       <= lowest[2];
                    bus.busy         <= !lowest[2];
                    bus.done         <= lowest[2];
                    state            <= lowest[2] ? DONE : SCAN;
                end else begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sudoku_group_scan.sv
// tb_sudoku_group_scan: randomized self-checking bench for sudoku_group_scan (BOX=3 and BOX=2)
module tb_sudoku_group_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sudoku_group_scan_if #(.BOX(3)) b3();
    sudoku_group_scan_if #(.BOX(2)) b2();
    sudoku_group_scan #(.BOX(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    sudoku_group_scan #(.BOX(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    int tests = 0;
    int fails = 0;
    bit cm [9][9][9];
    int m_cnt, m_fc, m_fg, m_cyc;
    bit m_conf, m_inc, m_solved;
    int cyc, busy_n, res_at1;

    function automatic bit in_group(int c, int a, int b, int x, int y, int z, int box);
        case (c)
            0:       return x == a && y == b;
            1:       return y == a && z == b;
            2:       return x == a && z == b;
            default: return z == b && (x / box) * box + y / box == a;
        endcase
    endfunction

    // Reference: walk enabled classes in order, count set cells belonging to each group.
    task automatic model(input int box, input bit [3:0] en, input bit stop);
        int s, n;
        bit halt;
        s = box * box;
        halt = 0;
        m_cnt = 0; m_fc = 0; m_fg = 0; m_conf = 0; m_inc = 0; m_cyc = 1;
        for (int c = 0; c < 4; c++)
            for (int g = 0; g < s * s; g++)
                if (en[c] && !halt) begin
                    n = 0;
                    for (int x = 0; x < s; x++)
                        for (int y = 0; y < s; y++)
                            for (int z = 0; z < s; z++)
                                if (cm[x][y][z] && in_group(c, g / s, g % s, x, y, z, box)) n++;
                    m_cyc++;
                    if (n == 0) m_inc = 1;
                    if (n > 1) begin
                        if (!m_conf) begin m_fc = c; m_fg = g; end
                        m_conf = 1;
                        m_cnt++;
                        halt = stop;
                    end
                end
        m_solved = !m_conf && !m_inc;
    endtask

    function automatic logic [728:0] pack3();
        logic [728:0] v;
        v = '0;
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
                for (int z = 0; z < 9; z++) v[x*81 + y*9 + z] = cm[x][y][z];
        return v;
    endfunction

    function automatic logic [63:0] pack2();
        logic [63:0] v;
        v = '0;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int z = 0; z < 4; z++) v[x*16 + y*4 + z] = cm[x][y][z];
        return v;
    endfunction

    task automatic clear_cube();
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
                for (int z = 0; z < 9; z++) cm[x][y][z] = 0;
    endtask

    // Pattern solution with a random digit relabelling.
    task automatic set_grid(input int box);
        int s, j, t;
        int perm [9];
        s = box * box;
        for (int i = 0; i < 9; i++) perm[i] = i;
        for (int i = s - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        clear_cube();
        for (int x = 0; x < s; x++)
            for (int y = 0; y < s; y++) cm[x][y][perm[(box * (x % box) + x / box + y) % s]] = 1;
    endtask

    task automatic flip_bits(input int box, input int k);
        int x, y, z;
        for (int i = 0; i < k; i++) begin
            x = int'($urandom_range(box * box - 1, 0));
            y = int'($urandom_range(box * box - 1, 0));
            z = int'($urandom_range(box * box - 1, 0));
            cm[x][y][z] = !cm[x][y][z];
        end
    endtask

    // Called at a negedge; leaves at the negedge of the done cycle (cyc = -1 on timeout).
    task automatic scan3(input bit [3:0] en, input bit stop);
        b3.cube = pack3(); b3.class_en = en; b3.stop_on_conflict = stop; b3.start = 1;
        @(posedge clk);
        @(negedge clk);
        b3.start = 0;
        cyc = 1; busy_n = 0;
        res_at1 = int'(b3.conflict_cnt) + int'(b3.conflict) + int'(b3.incomplete);
        while (!b3.done && cyc < 400) begin busy_n += int'(b3.busy); @(negedge clk); cyc++; end
        if (!b3.done) cyc = -1;
    endtask

    task automatic scan2(input bit [3:0] en, input bit stop);
        b2.cube = pack2(); b2.class_en = en; b2.stop_on_conflict = stop; b2.start = 1;
        @(posedge clk);
        @(negedge clk);
        b2.start = 0;
        cyc = 1;
        while (!b2.done && cyc < 200) begin @(negedge clk); cyc++; end
        if (!b2.done) cyc = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if ({b3.busy, b3.done, b3.solved, b3.conflict, b3.incomplete, b3.conflict_cnt, b3.first_cls, b3.first_grp} !== '0) begin
            fails++; $display("FAIL reset_outputs3 got busy=%b done=%b solved=%b cnt=%0d expected all 0", b3.busy, b3.done, b3.solved, b3.conflict_cnt);
        end
        tests++; if ({b2.busy, b2.done, b2.solved, b2.conflict, b2.incomplete, b2.conflict_cnt} !== '0) begin
            fails++; $display("FAIL reset_outputs2 got busy=%b done=%b solved=%b expected all 0", b2.busy, b2.done, b2.solved);
        end
        rst_n = 1;
        @(negedge clk);
        tests++; if ({b3.busy, b3.done, b3.solved} !== 3'b000) begin
            fails++; $display("FAIL idle_after_reset got %b expected 000", {b3.busy, b3.done, b3.solved});
        end
    endtask

    task automatic test_solved();
        set_grid(3);
        scan3(4'hF, 0);
        tests++; if (cyc !== 325) begin fails++; $display("FAIL solved_done_cycle got %0d expected 325", cyc); end
        tests++; if (busy_n !== 324) begin fails++; $display("FAIL solved_busy_cycles got %0d expected 324", busy_n); end
        tests++; if (b3.busy !== 1'b0) begin fails++; $display("FAIL busy_in_done got %b expected 0", b3.busy); end
        tests++; if ({b3.solved, b3.conflict, b3.incomplete} !== 3'b100) begin
            fails++; $display("FAIL solved_flags got %b expected 100", {b3.solved, b3.conflict, b3.incomplete});
        end
        tests++; if (b3.conflict_cnt !== 9'd0) begin fails++; $display("FAIL solved_cnt got %0d expected 0", b3.conflict_cnt); end
        @(negedge clk);
        tests++; if ({b3.done, b3.solved} !== 2'b01) begin fails++; $display("FAIL hold_after_done got %b expected 01", {b3.done, b3.solved}); end
    endtask

    task automatic test_conflict();
        int d;
        set_grid(3);
        d = 0;
        for (int z = 0; z < 9; z++) if (cm[0][0][z]) d = z;
        for (int z = 0; z < 9; z++) cm[4][0][z] = (z == d);
        scan3(4'hF, 0);
        tests++; if (cyc !== 325) begin fails++; $display("FAIL conflict_done_cycle got %0d expected 325", cyc); end
        tests++; if (res_at1 !== 0) begin fails++; $display("FAIL results_clear_cycle1 got %0d expected 0", res_at1); end
        tests++; if (b3.conflict_cnt !== 9'd3) begin fails++; $display("FAIL conflict_cnt got %0d expected 3", b3.conflict_cnt); end
        tests++; if ({b3.solved, b3.conflict, b3.incomplete} !== 3'b011) begin
            fails++; $display("FAIL conflict_flags got %b expected 011", {b3.solved, b3.conflict, b3.incomplete});
        end
        tests++; if (b3.first_cls !== 2'd1 || int'(b3.first_grp) !== d) begin
            fails++; $display("FAIL conflict_first got cls=%0d grp=%0d expected cls=1 grp=%0d", b3.first_cls, b3.first_grp, d);
        end
        scan3(4'hF, 1);
        tests++; if (cyc !== 83 + d) begin fails++; $display("FAIL stop_done_cycle got %0d expected %0d", cyc, 83 + d); end
        tests++; if (b3.conflict_cnt !== 9'd1) begin fails++; $display("FAIL stop_cnt got %0d expected 1", b3.conflict_cnt); end
        tests++; if (b3.first_cls !== 2'd1 || int'(b3.first_grp) !== d || b3.solved !== 1'b0) begin
            fails++; $display("FAIL stop_first got cls=%0d grp=%0d solved=%b expected cls=1 grp=%0d solved=0", b3.first_cls, b3.first_grp, b3.solved, d);
        end
    endtask

    task automatic test_empty();
        clear_cube();
        scan3(4'b0001, 0);
        tests++; if (cyc !== 82) begin fails++; $display("FAIL empty_done_cycle got %0d expected 82", cyc); end
        tests++; if ({b3.solved, b3.conflict, b3.incomplete} !== 3'b001) begin
            fails++; $display("FAIL empty_flags got %b expected 001", {b3.solved, b3.conflict, b3.incomplete});
        end
        scan3(4'b0000, 0);
        tests++; if (cyc !== 1) begin fails++; $display("FAIL noclass_done_cycle got %0d expected 1", cyc); end
        tests++; if ({b3.solved, b3.conflict, b3.incomplete, b3.busy} !== 4'b1000) begin
            fails++; $display("FAIL noclass_flags got %b expected 1000", {b3.solved, b3.conflict, b3.incomplete, b3.busy});
        end
    endtask

    task automatic test_start_ignored();
        set_grid(3);
        b3.cube = pack3(); b3.class_en = 4'hF; b3.stop_on_conflict = 0; b3.start = 1;
        @(posedge clk);
        @(negedge clk);
        b3.start = 0;
        cyc = 1;
        repeat (49) begin @(negedge clk); cyc++; end
        b3.start = 1; b3.cube = '0; b3.class_en = 4'b0001; b3.stop_on_conflict = 1;
        @(negedge clk);
        cyc++;
        b3.start = 0;
        while (!b3.done && cyc < 400) begin @(negedge clk); cyc++; end
        if (!b3.done) cyc = -1;
        tests++; if (cyc !== 325) begin fails++; $display("FAIL midscan_start_cycle got %0d expected 325", cyc); end
        tests++; if ({b3.solved, b3.conflict, b3.incomplete} !== 3'b100) begin
            fails++; $display("FAIL midscan_start_flags got %b expected 100", {b3.solved, b3.conflict, b3.incomplete});
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_grid(3);
        b3.cube = pack3(); b3.class_en = 4'hF; b3.stop_on_conflict = 0; b3.start = 1;
        @(posedge clk);
        @(negedge clk);
        b3.start = 0;
        repeat (99) @(negedge clk);
        #1 rst_n = 0;
        #1;
        tests++; if ({b3.busy, b3.done, b3.solved, b3.conflict, b3.incomplete, b3.conflict_cnt, b3.first_cls, b3.first_grp} !== '0) begin
            fails++; $display("FAIL midscan_reset got busy=%b done=%b cnt=%0d expected all 0", b3.busy, b3.done, b3.conflict_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (400) begin @(negedge clk); seen |= b3.done; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL done_after_reset got %b expected 0", seen); end
        scan3(4'hF, 0);
        tests++; if (cyc !== 325 || b3.solved !== 1'b1) begin
            fails++; $display("FAIL rescan_after_reset got cycle=%0d solved=%b expected 325 1", cyc, b3.solved);
        end
    endtask

    task automatic test_random3();
        bit [3:0] en;
        bit stop;
        for (int it = 0; it < 6; it++) begin
            set_grid(3);
            flip_bits(3, int'($urandom_range(4, 0)));
            en = 4'($urandom_range(15, 0));
            stop = 1'($urandom_range(1, 0));
            model(3, en, stop);
            scan3(en, stop);
            tests++; if (cyc !== m_cyc) begin fails++; $display("FAIL rand3_cycle it=%0d got %0d expected %0d", it, cyc, m_cyc); end
            tests++; if ({b3.solved, b3.conflict, b3.incomplete} !== {m_solved, m_conf, m_inc}) begin
                fails++; $display("FAIL rand3_flags it=%0d got %b expected %b", it, {b3.solved, b3.conflict, b3.incomplete}, {m_solved, m_conf, m_inc});
            end
            tests++; if (int'(b3.conflict_cnt) !== m_cnt || int'(b3.first_cls) !== m_fc || int'(b3.first_grp) !== m_fg) begin
                fails++; $display("FAIL rand3_counts it=%0d got cnt=%0d cls=%0d grp=%0d expected %0d %0d %0d", it, b3.conflict_cnt, b3.first_cls, b3.first_grp, m_cnt, m_fc, m_fg);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit [3:0] en;
        bit stop;
        set_grid(2);
        scan2(4'hF, 0);
        tests++; if (cyc !== 65 || b2.solved !== 1'b1) begin
            fails++; $display("FAIL box2_solved got cycle=%0d solved=%b expected 65 1", cyc, b2.solved);
        end
        flip_bits(2, 1);
        model(2, 4'hF, 0);
        scan2(4'hF, 0);
        tests++; if (cyc !== 65) begin fails++; $display("FAIL box2_back_to_back got %0d expected 65", cyc); end
        tests++; if (int'(b2.conflict_cnt) !== m_cnt || b2.solved !== m_solved || b2.incomplete !== m_inc) begin
            fails++; $display("FAIL box2_b2b_result got cnt=%0d solved=%b inc=%b expected %0d %b %b", b2.conflict_cnt, b2.solved, b2.incomplete, m_cnt, m_solved, m_inc);
        end
        for (int it = 0; it < 8; it++) begin
            set_grid(2);
            flip_bits(2, int'($urandom_range(3, 0)));
            en = 4'($urandom_range(15, 0));
            stop = 1'($urandom_range(1, 0));
            model(2, en, stop);
            scan2(en, stop);
            tests++; if (cyc !== m_cyc || {b2.solved, b2.conflict, b2.incomplete} !== {m_solved, m_conf, m_inc}) begin
                fails++; $display("FAIL rand2_flags it=%0d got cycle=%0d flags=%b expected %0d %b", it, cyc, {b2.solved, b2.conflict, b2.incomplete}, m_cyc, {m_solved, m_conf, m_inc});
            end
            tests++; if (int'(b2.conflict_cnt) !== m_cnt || int'(b2.first_cls) !== m_fc || int'(b2.first_grp) !== m_fg) begin
                fails++; $display("FAIL rand2_counts it=%0d got cnt=%0d cls=%0d grp=%0d expected %0d %0d %0d", it, b2.conflict_cnt, b2.first_cls, b2.first_grp, m_cnt, m_fc, m_fg);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        b3.start = 0; b3.cube = '0; b3.class_en = '0; b3.stop_on_conflict = 0;
        b2.start = 0; b2.cube = '0; b2.class_en = '0; b2.stop_on_conflict = 0;
        test_reset();
        test_solved();
        test_conflict();
        test_empty();
        test_start_ignored();
        test_reset_mid();
        test_random3();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
